auth_verifier: RTL and testbench

- Initiator and checker for the 128-bit NLFSR authentication core.
- On request, it seeds the core with a challenge, programs the run length, and starts it. It then waits for the core's done flag, captures the 128-bit response and Hamming-compares it against a golden signature.
- It reports pass/fail against a programmable distance threshold.
- It sits between the host/test controller and the signature generator, driving that generator's load, counter-load, start, seed and cycle inputs.

---
 rtl/auth_verifier.sv | 141 ++++++++++++++
 tb/tb_auth_verifier.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/auth_verifier.sv
// Challenge/response checker for the 128-bit NLFSR authentication core.
// Seeds and runs the generator, then Hamming-compares its response to a golden value.
module auth_verifier #(
  parameter int CHUNK_W        = 16,
  parameter int TIMEOUT_MARGIN = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req,
  input  logic [127:0] challenge,
  input  logic [31:0]  cycle_in,
  input  logic [127:0] golden,
  input  logic [7:0]   threshold,
  output logic [127:0] gen_seed,
  output logic [31:0]  gen_cycle,
  output logic         gen_load,
  output logic         gen_cnt_load,
  output logic         gen_start_cnt,
  input  logic [127:0] gen_response,
  input  logic         gen_cnt_done,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [7:0]   hd,
  output logic         timeout_err
);

  localparam int NCH = 128 / CHUNK_W;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, RUN, CMP, REPORT, ABORT
  } state_t;

  state_t state, state_n;

  logic [127:0]       golden_reg;
  logic [127:0]       diff_reg;
  logic [7:0]         thr_reg;
  logic [7:0]         acc;
  logic [7:0]         acc_n;
  logic [7:0]         pc;
  logic [32:0]        wd;
  logic [32:0]        wd_lim;
  logic [IW-1:0]      idx;
  logic [CHUNK_W-1:0] chunk;
  logic               last_chunk;
  logic               wd_hit;

  // diff_reg shifts right each compare cycle, so the low slice is current
  assign chunk = diff_reg[CHUNK_W-1:0];

  always_comb begin
    pc = '0;
    for (int i = 0; i < CHUNK_W; i++)
      pc = pc + 8'(chunk[i]);
  end

  assign acc_n      = acc + pc;
  assign wd_lim     = {1'b0, gen_cycle} + 33'(TIMEOUT_MARGIN);
  assign wd_hit     = (wd == wd_lim);
  assign last_chunk = (idx == IW'(NCH - 1));

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (req) state_n = LOAD;
      LOAD:    state_n = RUN;
      RUN: begin
        if (gen_cnt_done) state_n = CMP;
        else if (wd_hit)  state_n = ABORT;
      end
      CMP:     if (last_chunk) state_n = REPORT;
      REPORT:  state_n = IDLE;
      ABORT:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != IDLE);
    gen_load      = (state == LOAD);
    gen_cnt_load  = (state == LOAD);
    gen_start_cnt = (state == RUN);
    done          = (state == REPORT) || (state == ABORT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      gen_seed    <= '0;
      gen_cycle   <= '0;
      golden_reg  <= '0;
      thr_reg     <= '0;
      diff_reg    <= '0;
      wd          <= '0;
      acc         <= '0;
      idx         <= '0;
      pass        <= 1'b0;
      hd          <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (req) begin
            gen_seed    <= challenge;
            gen_cycle   <= cycle_in;
            golden_reg  <= golden;
            thr_reg     <= threshold;
            pass        <= 1'b0;
            hd          <= '0;
            timeout_err <= 1'b0;
          end
        end
        LOAD: wd <= '0;
        RUN: begin
          wd <= wd + 33'd1;
          if (gen_cnt_done) begin
            diff_reg <= gen_response ^ golden_reg;
            acc      <= '0;
            idx      <= '0;
          end else if (wd_hit) begin
            timeout_err <= 1'b1;
          end
        end
        CMP: begin
          acc      <= acc_n;
          diff_reg <= diff_reg >> CHUNK_W;
          idx      <= idx + IW'(1);
          if (last_chunk) begin
            hd   <= acc_n;
            pass <= (acc_n <= thr_reg);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_auth_verifier.sv
// Randomized self-checking bench for auth_verifier.
// A driven stub or a small NLFSR model plays the generator.
module tb_auth_verifier;

  logic         clk = 1'b0;
  logic         rst;
  logic         req;
  logic [127:0] challenge;
  logic [31:0]  cycle_in;
  logic [127:0] golden;
  logic [7:0]   threshold;
  logic [127:0] gen_seed;
  logic [31:0]  gen_cycle;
  logic         gen_load;
  logic         gen_cnt_load;
  logic         gen_start_cnt;
  logic [127:0] gen_response;
  logic         gen_cnt_done;
  logic         busy;
  logic         done;
  logic         pass;
  logic [7:0]   hd;
  logic         timeout_err;

  logic [127:0] resp_drv;
  logic         done_drv;
  logic         use_gen;
  logic [127:0] gst;
  logic [31:0]  gcnt;
  logic         garm;

  int n_chk  = 0;
  int n_pass = 0;
  int loads  = 0;
  int cloads = 0;

  auth_verifier dut (
    .clk(clk), .rst(rst), .req(req),
    .challenge(challenge), .cycle_in(cycle_in),
    .golden(golden), .threshold(threshold),
    .gen_seed(gen_seed), .gen_cycle(gen_cycle),
    .gen_load(gen_load), .gen_cnt_load(gen_cnt_load),
    .gen_start_cnt(gen_start_cnt),
    .gen_response(gen_response),
    .gen_cnt_done(gen_cnt_done),
    .busy(busy), .done(done), .pass(pass),
    .hd(hd), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] nl_step(input logic [127:0] s);
    logic [127:0] r;
    logic [31:0]  w;
    logic         fb;
    for (int j = 0; j < 4; j++) begin
      w  = s[32*j +: 32];
      fb = w[31] ^ w[28] ^ w[15] ^ (w[9] & w[3]);
      r[32*j +: 32] = {w[30:0], fb};
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      gst  <= '0;
      gcnt <= '0;
      garm <= 1'b0;
    end else begin
      if (gen_cnt_load) begin
        gcnt <= gen_cycle;
        garm <= 1'b1;
      end else if (gen_start_cnt && gcnt != 0) begin
        gcnt <= gcnt - 1;
      end
      if (gen_load)
        gst <= gen_seed;
      else if (gen_start_cnt && gcnt != 0)
        gst <= nl_step(gst);
    end
  end

  assign gen_response = use_gen ? gst : resp_drv;
  assign gen_cnt_done = use_gen ?
    (garm && gcnt == 0 && gen_start_cnt) : done_drv;

  always @(negedge clk) begin
    if (gen_load) loads++;
    if (gen_cnt_load) cloads++;
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic run(input logic [127:0] ch,
                     input logic [127:0] gold,
                     input logic [127:0] resp,
                     input logic [31:0]  cyc,
                     input logic [7:0]   thr,
                     input int           done_at,
                     input bit           req_mid);
    longint lim;
    int     k_end;
    int     hd_e;
    int     n;
    int     l0;
    int     c0;
    bit     ab;
    bit     p_e;
    lim   = longint'(cyc) + 16;
    ab    = !(done_at >= 0 && done_at <= lim);
    k_end = ab ? int'(lim) : done_at;
    hd_e  = $countones(resp ^ gold);
    p_e   = (hd_e <= int'(thr));
    l0    = loads;
    c0    = cloads;
    @(negedge clk);
    challenge = ch;
    golden    = gold;
    cycle_in  = cyc;
    threshold = thr;
    resp_drv  = resp;
    done_drv  = 1'b0;
    req       = 1'b1;
    @(negedge clk);
    req       = 1'b0;
    challenge = ~ch;
    golden    = ~gold;
    cycle_in  = ~cyc;
    threshold = ~thr;
    chk("load", {gen_load, gen_cnt_load, busy}, 3'b111);
    chk("seed", gen_seed, ch);
    chk("cycle", gen_cycle, cyc);
    for (int k = 0; k <= k_end; k++) begin
      @(negedge clk);
      if (k == 0) chk("run", {gen_start_cnt, gen_load}, 2'b10);
      done_drv = (k == done_at);
      req      = req_mid && (k == 1);
    end
    @(negedge clk);
    done_drv = 1'b0;
    req      = 1'b0;
    if (ab) begin
      chk("abort", {done, timeout_err, pass}, 3'b110);
      chk("abort_hd", hd, 0);
      @(negedge clk);
      chk("abort_after", {gen_start_cnt, done, busy}, 3'b000);
    end else begin
      n = 1;
      while (!done && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("latency", n, 9);
      chk("hd", hd, hd_e);
      chk("pass", pass, p_e);
      chk("timeout", timeout_err, 0);
      @(negedge clk);
      chk("hold", {done, hd, pass}, {1'b0, 8'(hd_e), p_e});
    end
    chk("load_pulses", {loads - l0, cloads - c0}, {32'd1, 32'd1});
  endtask

  initial begin
    logic [127:0] g;
    logic [127:0] m;
    logic [127:0] seed;
    logic [127:0] refr;
    int           n;
    int           cyc;
    int           da;
    rst       = 1'b1;
    req       = 1'b0;
    challenge = '0;
    cycle_in  = '0;
    golden    = '0;
    threshold = '0;
    resp_drv  = '0;
    done_drv  = 1'b0;
    use_gen   = 1'b0;
    #1;
    chk("reset_out", {busy, done, pass, timeout_err, hd,
                      gen_load, gen_cnt_load, gen_start_cnt}, 0);
    chk("reset_seed", {gen_seed, gen_cycle}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    g = {$urandom, $urandom, $urandom, $urandom};
    run(128'h1111_2222_3333_4444_5555_6666_7777_8888,
        g, g, 32'd20, 8'd0, 5, 1'b0);

    m = '0;
    m[0] = 1'b1; m[17] = 1'b1; m[63] = 1'b1;
    m[64] = 1'b1; m[127] = 1'b1;
    run(128'hA5, g, g ^ m, 32'd8, 8'd4, 3, 1'b0);
    run(128'hA5, g, g ^ m, 32'd8, 8'd5, 3, 1'b0);

    run(128'h5A, g, ~g, 32'd8, 8'd127, 2, 1'b0);
    run(128'h5A, g, ~g, 32'd8, 8'd128, 2, 1'b0);

    run(128'h77, g, g, 32'd10, 8'd10, -1, 1'b0);
    run(128'h78, g, g, 32'd0, 8'd10, -1, 1'b0);

    run(128'h99, g, g ^ m, 32'd10, 8'd5, 26, 1'b1);

    @(negedge clk);
    challenge = 128'hDEAD_BEEF;
    golden    = g;
    cycle_in  = 32'd4;
    threshold = 8'd0;
    resp_drv  = g;
    req       = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    done_drv = 1'b1;
    @(negedge clk);
    done_drv = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out", {busy, done, pass, timeout_err, hd,
                       gen_load, gen_cnt_load, gen_start_cnt}, 0);
    chk("midrst_seed", {gen_seed, gen_cycle}, 0);
    @(negedge clk);
    rst = 1'b0;
    run(128'hDEAD_BEEF, g, g, 32'd4, 8'd0, 2, 1'b0);

    use_gen = 1'b1;
    seed = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    refr = seed;
    for (int i = 0; i < 100; i++) refr = nl_step(refr);
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      challenge = seed;
      golden    = (t == 0) ? refr : refr ^ 128'h1;
      cycle_in  = 32'd100;
      threshold = 8'd0;
      req       = 1'b1;
      @(negedge clk);
      req = 1'b0;
      n = 0;
      while (!done && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk("gen_done", done, 1'b1);
      chk("gen_hd", hd, (t == 0) ? 0 : 1);
      chk("gen_pass", {pass, timeout_err}, (t == 0) ? 2'b10 : 2'b00);
    end
    use_gen = 1'b0;

    for (int it = 0; it < 25; it++) begin
      g = {$urandom, $urandom, $urandom, $urandom};
      m = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 2))
        0: m = m & {$urandom, $urandom, $urandom, $urandom}
                 & {$urandom, $urandom, $urandom, $urandom};
        1: ;
        default: m = '0;
      endcase
      cyc = int'($urandom_range(0, 20));
      da  = ($urandom_range(0, 3) == 0) ? -1
          : int'($urandom_range(0, cyc + 18));
      run({$urandom, $urandom, $urandom, $urandom}, g, g ^ m,
          32'(cyc), 8'($urandom_range(0, 140)), da,
          bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
